// File: rtl/integrate_dump_acc_pkg.sv
// Shared definitions for the integrate-and-dump accumulator and its adder stage.
// Sign-mode encodings, range-bound helper and clog2 for counter sizing.
package integrate_dump_acc_pkg;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    typedef struct packed {
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
    } bounds_t;

    // Representable range of a width-bit value interpreted in the given mode.
    function automatic bounds_t mode_bounds(input int width, input logic mode);
        bounds_t b;
        if (mode == MODE_SIGNED) begin
            b.max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
            b.min_v = -(64'sd1 <<< (width - 1));
        end else begin
            b.max_v = (64'sd1 <<< width) - 64'sd1;
            b.min_v = 64'sd0;
        end
        return b;
    endfunction

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/integrate_dump_acc_sat_add_ext.sv
// Combinational extend-and-add with overflow detection; clamps to the mode's range
// when INTEGRATE_SATURATE_EN is defined, otherwise wraps modulo 2^ACC_W.
module sat_add_ext
    import integrate_dump_acc_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IN_W-1:0]  din,
    input  logic             mode,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam int EXT_W = ACC_W + 1;

    logic [EXT_W-1:0] ext_acc;
    logic [EXT_W-1:0] ext_din;
    logic [EXT_W-1:0] wide;
    logic             sign_fill;
`ifdef INTEGRATE_SATURATE_EN
    bounds_t          bnd;
`endif

    always_comb begin
        sign_fill = (mode == MODE_SIGNED) && din[IN_W-1];
        ext_din   = {{(EXT_W - IN_W){sign_fill}}, din};
        ext_acc   = {(mode == MODE_SIGNED) && acc[ACC_W-1], acc};
        wide      = ext_acc + ext_din;
        // Signed: the extra bit disagrees with the ACC_W sign bit; unsigned: carry out.
        if (mode == MODE_SIGNED) begin
            ovf = wide[ACC_W] ^ wide[ACC_W-1];
        end else begin
            ovf = wide[ACC_W];
        end
`ifdef INTEGRATE_SATURATE_EN
        bnd = mode_bounds(ACC_W, mode);
        sum = wide[ACC_W-1:0];
        if (ovf) begin
            if ((mode == MODE_SIGNED) && wide[ACC_W]) begin
                sum = bnd.min_v[ACC_W-1:0];
            end else begin
                sum = bnd.max_v[ACC_W-1:0];
            end
        end
`else
        sum = wide[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/integrate_dump_acc.sv
// Integrate-and-dump accumulator: sums LEN valid samples per block and emits one result.
// Build option INTEGRATE_SATURATE_EN selects clamping instead of wrapping arithmetic.
module integrate_dump_acc
    import integrate_dump_acc_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int ACC_W = 8,
    parameter int LEN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             sign_mode,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] dout,
    output logic             dout_valid,
    output logic             dout_signed,
    output logic             ovf
);

    localparam int             CNT_W = clog2(LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             ovf_q;
    logic             first;
    logic             last;
    logic             add_mode;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;

    // The first sample of a block uses the live mode; later samples use the latch.
    assign first    = (cnt == '0);
    assign last     = (cnt == LAST);
    assign add_mode = first ? sign_mode : mode_q;

    sat_add_ext #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc  (acc),
        .din  (din),
        .mode (add_mode),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            mode_q      <= MODE_UNSIGNED;
            ovf_q       <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_signed <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (clr) begin
                acc   <= '0;
                cnt   <= '0;
                ovf_q <= 1'b0;
            end else if (din_valid) begin
                if (first) begin
                    mode_q <= sign_mode;
                end
                if (last) begin
                    dout        <= sum;
                    ovf         <= ovf_q | add_ovf;
                    dout_signed <= mode_q;
                    dout_valid  <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf_q       <= 1'b0;
                end else begin
                    acc   <= sum;
                    cnt   <= cnt + CNT_W'(1);
                    ovf_q <= ovf_q | add_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_integrate_dump_acc.sv
// Bench for integrate_dump_acc: an 8-bit and a 5-bit accumulator share one stimulus
// stream and are checked every cycle against an integer model of block summation.
module tb_integrate_dump_acc;

    localparam int IN_W = 4;
    localparam int LEN  = 8;
`ifdef INTEGRATE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            clr;
    logic            sign_mode;
    logic            din_valid;
    logic [IN_W-1:0] din;

    logic [7:0] dout8;
    logic       dv8, ds8, ov8;
    logic [4:0] dout5;
    logic       dv5, ds5, ov5;

    integrate_dump_acc #(.IN_W(IN_W), .ACC_W(8), .LEN(LEN)) u_dut8 (
        .clk(clk), .rst(rst), .clr(clr), .sign_mode(sign_mode),
        .din_valid(din_valid), .din(din),
        .dout(dout8), .dout_valid(dv8), .dout_signed(ds8), .ovf(ov8)
    );

    integrate_dump_acc #(.IN_W(IN_W), .ACC_W(5), .LEN(LEN)) u_dut5 (
        .clk(clk), .rst(rst), .clr(clr), .sign_mode(sign_mode),
        .din_valid(din_valid), .din(din),
        .dout(dout5), .dout_valid(dv5), .dout_signed(ds5), .ovf(ov5)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: running integer sum per block, per accumulator width.
    int aw[2] = '{8, 5};
    int m_acc[2];
    int m_n[2];
    bit m_mode[2];
    bit m_ovf[2];
    int e_dout[2];
    bit e_valid[2];
    bit e_signed[2];
    bit e_ovf[2];
    logic [7:0] exp_q[$];

    function automatic int wrap_to(input int s, input int w, input bit sgn);
        int m;
        m = s % (1 << w);
        if (m < 0) m = m + (1 << w);
        if (sgn && m >= (1 << (w - 1))) m = m - (1 << w);
        return m;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int v, s, lo, hi;
            bit md, o;
            if (rst) begin
                m_acc[i] = 0; m_n[i] = 0; m_mode[i] = 0; m_ovf[i] = 0;
                e_dout[i] = 0; e_valid[i] = 0; e_signed[i] = 0; e_ovf[i] = 0;
            end else begin
                e_valid[i] = 0;
                if (clr) begin
                    m_acc[i] = 0; m_n[i] = 0; m_ovf[i] = 0;
                end else if (din_valid) begin
                    md = (m_n[i] == 0) ? sign_mode : m_mode[i];
                    if (m_n[i] == 0) m_mode[i] = sign_mode;
                    v = int'(din);
                    if (md && din[IN_W-1]) v = v - (1 << IN_W);
                    lo = md ? -(1 << (aw[i] - 1)) : 0;
                    hi = md ? (1 << (aw[i] - 1)) - 1 : (1 << aw[i]) - 1;
                    s = m_acc[i] + v;
                    o = (s < lo) || (s > hi);
                    if (o) s = SAT ? ((s > hi) ? hi : lo) : wrap_to(s, aw[i], md);
                    if (m_n[i] == LEN - 1) begin
                        e_dout[i] = s; e_ovf[i] = m_ovf[i] | o;
                        e_signed[i] = m_mode[i]; e_valid[i] = 1;
                        if (i == 0) exp_q.push_back(8'(s));
                        m_acc[i] = 0; m_n[i] = 0; m_ovf[i] = 0;
                    end else begin
                        m_acc[i] = s; m_n[i] = m_n[i] + 1; m_ovf[i] = m_ovf[i] | o;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Scoreboard: every cycle, both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [10:0] act, exp;
            logic [7:0]  ed;
            ed  = 8'(e_dout[i] & ((1 << aw[i]) - 1));
            exp = {e_valid[i], e_signed[i], e_ovf[i], ed};
            act = (i == 0) ? {dv8, ds8, ov8, dout8} : {dv5, ds5, ov5, 3'b000, dout5};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL cycle_cmp acc%0d t=%0t: got v=%b s=%b o=%b d=%h, want v=%b s=%b o=%b d=%h",
                         aw[i], $time, act[10], act[9], act[8], act[7:0],
                         exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
        if (dv8 === 1'b1) begin
            logic [7:0] q;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL exp_q_pop t=%0t: got dout=%h with no expected result queued", $time, dout8);
            end else begin
                q = exp_q.pop_front();
                if (dout8 !== q) begin
                    n_err++;
                    $display("FAIL exp_q_pop t=%0t: got dout=%h, want %h", $time, dout8, q);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %0d (0x%0h), want %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    // Driver: hold inputs for one rising edge, return 1 ns after it.
    task automatic cyc(input bit v, input logic [IN_W-1:0] d, input bit sm, input bit c);
        din_valid = v;
        din       = d;
        sign_mode = sm;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, sign_mode, 1'b0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; sign_mode = 1'b0; din_valid = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout8", int'(dout8), 0);
        check("reset_flags8", int'({dv8, ds8, ov8}), 0);
        check("reset_dout5", int'(dout5), 0);
        rst = 1'b0;
        idle();

        // Unsigned 8 x 15
        repeat (LEN) cyc(1'b1, 4'hF, 1'b0, 1'b0);
        check("u15_valid", int'(dv8), 1);
        check("u15_dout8", int'(dout8), 120);
        check("u15_model", e_dout[0], 120);
        check("u15_signed_ovf8", int'({ds8, ov8}), 0);
        check("u15_dout5", int'(dout5), SAT ? 31 : 24);
        check("u15_ovf5", int'(ov5), 1);
        idle();
        check("u15_strobe_drop", int'(dv8), 0);
        check("u15_hold", int'(dout8), 120);

        // Signed 8 x -1, mode toggled after the first sample
        cyc(1'b1, 4'hF, 1'b1, 1'b0);
        repeat (LEN - 1) cyc(1'b1, 4'hF, 1'b0, 1'b0);
        check("s_m1_dout8", int'(dout8), 8'hF8);
        check("s_m1_signed8", int'(ds8), 1);
        check("s_m1_ovf8", int'(ov8), 0);
        check("s_m1_dout5", int'(dout5), 5'h18);
        idle();

        // Signed 8 x 7: fits in 8 bits, overflows 5 bits
        repeat (LEN) cyc(1'b1, 4'h7, 1'b1, 1'b0);
        check("s_7_dout8", int'(dout8), 8'h38);
        check("s_7_dout5", int'(dout5), SAT ? 5'h0F : 5'h18);
        check("s_7_ovf5", int'(ov5), 1);
        idle();

        // Gapped valids
        cyc(1'b1, 4'd1, 1'b0, 1'b0); idle(); idle();
        cyc(1'b1, 4'd2, 1'b0, 1'b0); idle(); idle();
        cyc(1'b1, 4'd3, 1'b0, 1'b0); idle(); idle();
        repeat (5) cyc(1'b1, 4'd1, 1'b0, 1'b0);
        check("gap_valid", int'(dv8), 1);
        check("gap_dout8", int'(dout8), 11);
        idle();

        // Abort mid-block, then a clean block, then clr on the dump cycle
        repeat (4) cyc(1'b1, 4'd3, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        repeat (LEN) cyc(1'b1, 4'd2, 1'b0, 1'b0);
        check("clr_dout8", int'(dout8), 16);
        check("clr_ovf8", int'(ov8), 0);
        repeat (LEN - 1) cyc(1'b1, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 4'd1, 1'b0, 1'b1);
        check("clr_dump_suppressed", int'(dv8), 0);
        check("clr_dump_hold", int'(dout8), 16);

        // Asynchronous reset mid-block
        repeat (5) cyc(1'b1, 4'd1, 1'b0, 1'b0);
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_dout8", int'(dout8), 0);
        check("async_rst_valid8", int'(dv8), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        repeat (LEN) cyc(1'b1, 4'd1, 1'b0, 1'b0);
        check("post_rst_dout8", int'(dout8), 8);
        idle();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 3) != 0), IN_W'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end
        cyc(1'b0, '0, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/integrate_dump_acc.md
Name: integrate_dump_acc

Overview:
Downstream consumer of the 4-bit signed/unsigned adder stage.
- Accumulates a stream of IN_W-bit samples over blocks of LEN valid samples (integrate-and-dump).
- Emits one ACC_W-bit result per block with a one-cycle valid strobe and an overflow flag.
- Same datapath handles two's-complement or unsigned samples, selected per block.
- Feeds the decimating filter stages.

Parameters:
- IN_W, 4, input sample width.
- ACC_W, 8, accumulator and output width; must be >= IN_W.
- LEN, 8, samples per block; must be >= 2. Counter width is clog2(LEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous block abort: clears accumulator and counter.
- sign_mode  in  1  1 = din is two's complement, 0 = din is unsigned.
- din_valid  in  1  din is qualified this cycle.
- din  in  IN_W  input sample.
- dout  out  ACC_W  block result; signed or unsigned per the latched mode.
- dout_valid  out  1  one-cycle strobe marking a new dout.
- dout_signed  out  1  sign mode that applied to the current dout.
- ovf  out  1  at least one overflow occurred in the block; valid with dout_valid.

Behaviour:
Reset
- rst asserted, asynchronous: acc=0, cnt=0, mode_q=0, ovf_q=0, dout=0, dout_valid=0, dout_signed=0, ovf=0.
- Reset mid-block discards the partial block. No dout_valid is produced for it.

Extension and addition
- din is sign-extended when the latched mode is 1, zero-extended when it is 0, to ACC_W+1 bits.
- The sum is computed at ACC_W+1 bits.
- Signed overflow: sum outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Unsigned overflow: sum > 2^ACC_W-1.

Mode latch
- sign_mode is sampled into mode_q on the first valid sample of a block (cnt==0).
- Changes to sign_mode mid-block are ignored until the next block.
- The first sample itself uses the live sign_mode value.

Accumulate (din_valid=1, cnt<LEN-1)
- acc <= acc + ext(din); cnt++.
- ovf_q |= overflow of this addition.

Dump (din_valid=1, cnt==LEN-1)
- dout <= acc + ext(din); ovf <= ovf_q | overflow of this addition; dout_signed <= mode_q.
- dout_valid=1 for exactly one cycle.
- acc, cnt and ovf_q return to 0.
- Latency: dout_valid rises on the clock edge that samples the LEN-th valid input, i.e. it is visible in the cycle after that input.

Other cycles
- din_valid=0: no state change; gaps of any length are allowed.
- dout and ovf hold their last values; dout_valid=0.

clr
- clr=1: acc=0, cnt=0, ovf_q=0. clr has priority over din_valid in the same cycle, and that sample is dropped.
- dout, ovf and dout_signed are unaffected.
- clr coinciding with the dump cycle suppresses that dump.

Back-to-back blocks
- A valid sample in the cycle after a dump begins the next block with no bubble.

Optional Feature:
Macro INTEGRATE_SATURATE_EN.
- Defined: every addition clamps to the range limit of the latched mode.
  - Signed: 2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - Unsigned: 2^ACC_W-1 (an unsigned sum cannot go below 0).
- Undefined: additions wrap modulo 2^ACC_W.
- ovf is reported identically in both builds.

Decomposition:
- Shared package:
  - Sign-mode encodings MODE_UNSIGNED=0 and MODE_SIGNED=1.
  - A function returning the max/min bounds for a given width and mode.
  - The clog2 helper.
- One natural sub-module: sat_add_ext.
  - Combinational: extend, add, detect overflow, optionally clamp.
  - Parameterised by IN_W and ACC_W.
  - Reused by the filter accumulators.
- Counter and control logic stay in the top level.

Test Plan:
1. Defaults; sign_mode=0; 8 consecutive samples of 4'hF -> one cycle later dout=8'd120, dout_signed=0, ovf=0, dout_valid high for 1 cycle.
2. Defaults; sign_mode=1; 8 samples of 4'hF (-1) -> dout=8'hF8 (-8), dout_signed=1, ovf=0. Toggling sign_mode after sample 1 changes nothing.
3. ACC_W=5; sign_mode=1; 8 samples of 4'h7 (sum 56):
   - with INTEGRATE_SATURATE_EN -> dout=5'h0F, ovf=1;
   - without it -> dout=5'h18, ovf=1.
4. Defaults; samples 1,2,3 with 2-cycle valid gaps between them, then 5 more samples of 1 -> dout=8'd11 exactly one cycle after the 8th valid sample; no strobe during the gaps.
5. Defaults; 4 samples of 3, then clr, then 8 samples of 2 -> single dump with dout=8'd16, ovf=0. clr asserted on the dump cycle -> no dout_valid.
6. Assert rst asynchronously after 5 samples -> dout=0, dout_valid=0 immediately. The next 8 samples of 1 -> dout=8'd8.
